// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the RV32I main-control decode stage.
//   - RV32I base opcode constants (instruction bits [6:0])
//   - ALU operation class encoding driven to the execute stage
//   - ctrl_word_t: decoded control bits plus the illegal-opcode flag
package ctrl_pkg;

   localparam logic [6:0] OP_R      = 7'd51;
   localparam logic [6:0] OP_I      = 7'd19;
   localparam logic [6:0] OP_LOAD   = 7'd3;
   localparam logic [6:0] OP_STORE  = 7'd35;
   localparam logic [6:0] OP_BRANCH = 7'd99;
   localparam logic [6:0] OP_JAL    = 7'd111;
   localparam logic [6:0] OP_JALR   = 7'd103;
   localparam logic [6:0] OP_LUI    = 7'd55;
   localparam logic [6:0] OP_AUIPC  = 7'd23;
   localparam logic [6:0] OP_FENCE  = 7'd15;
   localparam logic [6:0] OP_SYS    = 7'd115;

   typedef enum logic [1:0] {
      ALU_ADD = 2'd0,   // address generation
      ALU_BR  = 2'd1,   // branch compare
      ALU_R   = 2'd2,   // operation selected by R-type funct fields
      ALU_I   = 2'd3    // operation selected by I-type funct fields
   } alu_op_e;

   typedef struct packed {
      logic    branch;
      logic    jump;
      logic    mem_read;
      logic    mem_to_reg;
      logic    mem_write;
      logic    alu_src;
      logic    reg_write;
      logic    pc_src_a;
      logic    lui;
      alu_op_e alu_op;
      logic    illegal;
   } ctrl_word_t;

   // Control word for an undecodable instruction: no side-effects, only the flag.
   function automatic ctrl_word_t ctrl_illegal();
      ctrl_word_t c;
      c         = '0;
      c.illegal = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/ctrl_decode_comb.sv
// ctrl_decode_comb: purely combinational opcode -> control word mapping.
// Ports:
//   opcode_i  in   7  instruction bits [6:0]
//   ctrl_o    out     decoded control word (illegal set for unknown opcodes)
// EN_JUMP = 0 selects the legacy mode in which JAL/JALR/LUI/AUIPC are illegal.
module ctrl_decode_comb
   import ctrl_pkg::*;
#(
   parameter int EN_JUMP = 1
) (
   input  logic [6:0] opcode_i,
   output ctrl_word_t ctrl_o
);

   localparam bit JUMP_ON = (EN_JUMP != 0);

   always_comb begin
      ctrl_o = '0;
      case (opcode_i)
         OP_R: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.alu_op    = ALU_R;
         end
         OP_I: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.alu_op    = ALU_I;
         end
         OP_LOAD: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.mem_read   = 1'b1;
            ctrl_o.mem_to_reg = 1'b1;
            ctrl_o.alu_src    = 1'b1;
         end
         OP_STORE: begin
            ctrl_o.mem_write = 1'b1;
            ctrl_o.alu_src   = 1'b1;
         end
         OP_BRANCH: begin
            ctrl_o.branch = 1'b1;
            ctrl_o.alu_op = ALU_BR;
         end
         OP_JAL: begin
            if (JUMP_ON) begin
               ctrl_o.jump      = 1'b1;
               ctrl_o.reg_write = 1'b1;
               ctrl_o.pc_src_a  = 1'b1;
            end else begin
               ctrl_o = ctrl_illegal();
            end
         end
         OP_JALR: begin
            if (JUMP_ON) begin
               ctrl_o.jump      = 1'b1;
               ctrl_o.reg_write = 1'b1;
               ctrl_o.alu_src   = 1'b1;
            end else begin
               ctrl_o = ctrl_illegal();
            end
         end
         OP_LUI: begin
            if (JUMP_ON) begin
               ctrl_o.reg_write = 1'b1;
               ctrl_o.lui       = 1'b1;
               ctrl_o.alu_src   = 1'b1;
            end else begin
               ctrl_o = ctrl_illegal();
            end
         end
         OP_AUIPC: begin
            if (JUMP_ON) begin
               ctrl_o.reg_write = 1'b1;
               ctrl_o.pc_src_a  = 1'b1;
               ctrl_o.alu_src   = 1'b1;
            end else begin
               ctrl_o = ctrl_illegal();
            end
         end
         OP_FENCE, OP_SYS: begin
            // legal, but nothing for the datapath to do
         end
         default: ctrl_o = ctrl_illegal();
      endcase

      // Compressed-encoding space is not supported: low bits must be 2'b11.
      if (opcode_i[1:0] != 2'b11) begin
         ctrl_o = ctrl_illegal();
      end
   end

endmodule

// File: rtl/control_decode_stage.sv
// control_decode_stage: one elastic pipeline slot that decodes RV32I opcodes
// into a registered control word and counts illegal instructions.
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   in_valid/in_ready   upstream handshake (in_ready = !out_valid || out_ready)
//   instruction         instruction word, opcode in [6:0]
//   flush               drop the held entry and anything presented this cycle
//   out_valid/out_ready downstream handshake
//   out_instr           registered instruction
//   branch..lui, alu_op registered control bits
//   illegal             held entry has an undecoded opcode
//   illegal_cnt         saturating count of accepted illegal instructions
module control_decode_stage
   import ctrl_pkg::*;
#(
   parameter int ILEN    = 32,
   parameter int CNT_W   = 16,
   parameter int EN_JUMP = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [ILEN-1:0]  instruction,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ILEN-1:0]  out_instr,
   output logic             branch,
   output logic             jump,
   output logic             mem_read,
   output logic             mem_to_reg,
   output logic             mem_write,
   output logic             alu_src,
   output logic             reg_write,
   output logic             pc_src_a,
   output logic             lui,
   output logic [1:0]       alu_op,
   output logic             illegal,
   output logic [CNT_W-1:0] illegal_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   ctrl_word_t       dec_ctrl;
   logic             accept;

   logic             valid_q, valid_d;
   logic [ILEN-1:0]  instr_q, instr_d;
   ctrl_word_t       ctrl_q, ctrl_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   ctrl_decode_comb #(
      .EN_JUMP (EN_JUMP)
   ) u_decode (
      .opcode_i (instruction[6:0]),
      .ctrl_o   (dec_ctrl)
   );

   assign in_ready = !valid_q || out_ready;
   // Flush wins: a presented instruction is neither registered nor counted.
   assign accept   = in_valid && in_ready && !flush;

   always_comb begin
      valid_d = valid_q;
      instr_d = instr_q;
      ctrl_d  = ctrl_q;
      cnt_d   = cnt_q;

      if (flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d = 1'b1;
         instr_d = instruction;
         ctrl_d  = dec_ctrl;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end

      if (accept && dec_ctrl.illegal && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         instr_q <= '0;
         ctrl_q  <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         instr_q <= instr_d;
         ctrl_q  <= ctrl_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_valid   = valid_q;
   assign out_instr   = instr_q;
   assign branch      = ctrl_q.branch;
   assign jump        = ctrl_q.jump;
   assign mem_read    = ctrl_q.mem_read;
   assign mem_to_reg  = ctrl_q.mem_to_reg;
   assign mem_write   = ctrl_q.mem_write;
   assign alu_src     = ctrl_q.alu_src;
   assign reg_write   = ctrl_q.reg_write;
   assign pc_src_a    = ctrl_q.pc_src_a;
   assign lui         = ctrl_q.lui;
   assign alu_op      = ctrl_q.alu_op;
   assign illegal     = ctrl_q.illegal;
   assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_control_decode_stage.sv
module tb_control_decode_stage;

   // Expected control bits, packed in this order:
   // branch jump mem_read mem_to_reg mem_write alu_src reg_write pc_src_a lui alu_op[1:0] illegal
   typedef logic [11:0] exp_t;

   typedef struct {
      logic [31:0] instr;
      exp_t        e;
   } vec_t;

   typedef struct {
      logic [31:0] instr;
      exp_t        e;
   } sb_t;

   localparam exp_t E_ADD   = 12'b000000100_10_0;
   localparam exp_t E_LW    = 12'b001101100_00_0;
   localparam exp_t E_SW    = 12'b000011000_00_0;
   localparam exp_t E_BEQ   = 12'b100000000_01_0;
   localparam exp_t E_ADDI  = 12'b000001100_11_0;
   localparam exp_t E_JAL   = 12'b010000110_00_0;
   localparam exp_t E_JALR  = 12'b010001100_00_0;
   localparam exp_t E_LUI   = 12'b000001101_00_0;
   localparam exp_t E_AUIPC = 12'b000001110_00_0;
   localparam exp_t E_NONE  = 12'b000000000_00_0;
   localparam exp_t E_ILL   = 12'b000000000_00_1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // ---------------- DUT A: default parameters ----------------
   logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
   logic [31:0] instruction = '0;
   logic        in_ready, out_valid;
   logic [31:0] out_instr;
   logic        branch, jump, mem_read, mem_to_reg, mem_write, alu_src, reg_write, pc_src_a, lui, illegal;
   logic [1:0]  alu_op;
   logic [15:0] illegal_cnt;

   control_decode_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .instruction(instruction), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_instr(out_instr), .branch(branch), .jump(jump),
      .mem_read(mem_read), .mem_to_reg(mem_to_reg), .mem_write(mem_write),
      .alu_src(alu_src), .reg_write(reg_write), .pc_src_a(pc_src_a), .lui(lui),
      .alu_op(alu_op), .illegal(illegal), .illegal_cnt(illegal_cnt)
   );

   // ---------------- DUT B: legacy mode, 2-bit counter ----------------
   logic        b_in_valid = 1'b0, b_flush = 1'b0, b_out_ready = 1'b1;
   logic [31:0] b_instr = '0;
   logic        b_in_ready, b_out_valid;
   logic [31:0] b_out_instr;
   logic        b_branch, b_jump, b_mem_read, b_mem_to_reg, b_mem_write, b_alu_src, b_reg_write, b_pc_src_a, b_lui, b_illegal;
   logic [1:0]  b_alu_op;
   logic [1:0]  b_cnt;

   control_decode_stage #(.ILEN(32), .CNT_W(2), .EN_JUMP(0)) dut_b (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .instruction(b_instr), .flush(b_flush), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_instr(b_out_instr), .branch(b_branch), .jump(b_jump),
      .mem_read(b_mem_read), .mem_to_reg(b_mem_to_reg), .mem_write(b_mem_write),
      .alu_src(b_alu_src), .reg_write(b_reg_write), .pc_src_a(b_pc_src_a), .lui(b_lui),
      .alu_op(b_alu_op), .illegal(b_illegal), .illegal_cnt(b_cnt)
   );

   function automatic exp_t act_a();
      return {branch, jump, mem_read, mem_to_reg, mem_write, alu_src, reg_write, pc_src_a, lui, alu_op, illegal};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- scoreboard for DUT A ----------------
   sb_t  sb[$];
   exp_t cur_exp = E_NONE;
   int   pops = 0;

   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL sb_unexpected: output 0x%0h with empty scoreboard", out_instr);
            end else begin
               sb_t s;
               s = sb.pop_front();
               pops++;
               check("sb_instr", out_instr, s.instr);
               check("sb_ctrl", {20'd0, act_a()}, {20'd0, s.e});
            end
         end
         if (in_valid && in_ready && !flush) begin
            sb_t s;
            s.instr = instruction;
            s.e     = cur_exp;
            sb.push_back(s);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   vec_t tab[13];
   int   b_cnt_exp[5];
   logic [31:0] b_seq[5];

   initial begin
      tab[0]  = '{32'h00B50533, E_ADD};
      tab[1]  = '{32'h00052583, E_LW};
      tab[2]  = '{32'h00B52023, E_SW};
      tab[3]  = '{32'h00B50463, E_BEQ};
      tab[4]  = '{32'h00150513, E_ADDI};
      tab[5]  = '{32'h008000EF, E_JAL};
      tab[6]  = '{32'h000500E7, E_JALR};
      tab[7]  = '{32'h123452B7, E_LUI};
      tab[8]  = '{32'h00001297, E_AUIPC};
      tab[9]  = '{32'h0000000F, E_NONE};
      tab[10] = '{32'h00000073, E_NONE};
      tab[11] = '{32'h0000007F, E_ILL};
      tab[12] = '{32'h00B50530, E_ILL};   // R opcode with low bits 2'b00

      b_seq[0] = 32'h008000EF; b_cnt_exp[0] = 1;
      b_seq[1] = 32'h123452B7; b_cnt_exp[1] = 2;
      b_seq[2] = 32'h00001297; b_cnt_exp[2] = 3;
      b_seq[3] = 32'h0000007F; b_cnt_exp[3] = 3;
      b_seq[4] = 32'h000500E7; b_cnt_exp[4] = 3;

      // reset state
      cyc(); cyc();
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_cnt", {16'd0, illegal_cnt}, 32'd0);
      check("rst_ctrl", {20'd0, act_a()}, 32'd0);
      check("rst_instr", out_instr, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      rst = 1'b0;
      cyc();

      // table stream, back-to-back with out_ready high
      for (int i = 0; i < 13; i++) begin
         in_valid    = 1'b1;
         instruction = tab[i].instr;
         cur_exp     = tab[i].e;
         cyc();
         check("stream_valid", {31'd0, out_valid}, 32'd1);
      end
      in_valid = 1'b0;
      cyc(); cyc();
      check("stream_pops", pops, 13);
      check("stream_cnt", {16'd0, illegal_cnt}, 32'd2);
      check("stream_idle", {31'd0, out_valid}, 32'd0);

      // backpressure: lw held for 3 cycles, then pop + accept same edge
      in_valid = 1'b1; instruction = 32'h00052583; cur_exp = E_LW; out_ready = 1'b1;
      cyc();
      out_ready = 1'b0; instruction = 32'h00B50533; cur_exp = E_ADD;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
         check("bp_hold_instr", out_instr, 32'h00052583);
         check("bp_hold_ctrl", {20'd0, act_a()}, {20'd0, E_LW});
         check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         cyc();
      end
      out_ready = 1'b1;
      cyc();
      check("bp_next_instr", out_instr, 32'h00B50533);
      check("bp_next_valid", {31'd0, out_valid}, 32'd1);
      in_valid = 1'b0;
      cyc();
      check("bp_drain", {31'd0, out_valid}, 32'd0);

      // flush with an accepted illegal instruction presented
      in_valid = 1'b1; instruction = 32'h00B50533; cur_exp = E_ADD; out_ready = 1'b0;
      cyc();
      check("fl_pre_valid", {31'd0, out_valid}, 32'd1);
      instruction = 32'h0000007F; cur_exp = E_ILL; flush = 1'b1; out_ready = 1'b1;
      #1;
      check("fl_in_ready", {31'd0, in_ready}, 32'd1);
      cyc();
      flush = 1'b0; in_valid = 1'b0;
      check("fl_valid", {31'd0, out_valid}, 32'd0);
      check("fl_cnt", {16'd0, illegal_cnt}, 32'd2);

      // flush of a held entry with downstream stalled
      in_valid = 1'b1; instruction = 32'h00150513; cur_exp = E_ADDI; out_ready = 1'b0;
      cyc();
      in_valid = 1'b0; flush = 1'b1;
      cyc();
      flush = 1'b0;
      check("fl_held_valid", {31'd0, out_valid}, 32'd0);
      sb.delete();
      out_ready = 1'b1;
      cyc();

      // asynchronous reset with an entry held
      in_valid = 1'b1; instruction = 32'h00B50533; cur_exp = E_ADD; out_ready = 1'b0;
      cyc();
      check("mr_pre_valid", {31'd0, out_valid}, 32'd1);
      #2;
      rst = 1'b1; in_valid = 1'b0;
      #1;
      check("mr_valid", {31'd0, out_valid}, 32'd0);
      check("mr_cnt", {16'd0, illegal_cnt}, 32'd0);
      check("mr_ctrl", {20'd0, act_a()}, 32'd0);
      check("mr_instr", out_instr, 32'd0);
      sb.delete();
      cyc();
      rst = 1'b0; out_ready = 1'b1;
      cyc();
      check("mr_after", {31'd0, out_valid}, 32'd0);

      // DUT B: legacy mode jump-class illegal + saturating 2-bit counter
      for (int i = 0; i < 5; i++) begin
         b_in_valid = 1'b1;
         b_instr    = b_seq[i];
         cyc();
         check("b_valid", {31'd0, b_out_valid}, 32'd1);
         check("b_illegal", {31'd0, b_illegal}, 32'd1);
         check("b_cnt", {30'd0, b_cnt}, b_cnt_exp[i]);
         if (i == 0) begin
            check("b_jal_reg_write", {31'd0, b_reg_write}, 32'd0);
            check("b_jal_jump", {31'd0, b_jump}, 32'd0);
         end
      end
      b_in_valid = 1'b0;
      cyc();

      check("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
